// File: rtl/mem_bus_ctrl_pkg.sv
// Shared address-map definitions for the data-side memory bus controller
// and the address decoder it shares with the instruction fetch path.
package mem_map_pkg;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_GPIO,
    RGN_TMR,
    RGN_NONE
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [15:0] RAM_TOP       = 16'hF000;
  localparam logic [11:0] IO_PREFIX_DEF = 12'hF00;
  localparam logic [1:0]  GPIO_BLK      = 2'b00;
  localparam logic [1:0]  TMR_BLK       = 2'b01;

  function automatic logic is_io(input region_e rgn);
    return (rgn == RGN_GPIO) || (rgn == RGN_TMR);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Core, RAM and peripheral-control signals of the memory bus controller.
// The bidirectional peripheral data bus stays a plain port on the controller.
interface mem_bus_ctrl_if;
  logic        core_req;
  logic        core_wr;
  logic [15:0] core_addr;
  logic [15:0] core_wdata;
  logic [15:0] core_rdata;
  logic        core_ack;
  logic        core_err;
  logic [15:0] ram_addr;
  logic        ram_en;
  logic        ram_wr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [1:0]  io_addr;
  logic        io_wr;
  logic        io_en_gpio;
  logic        io_en_tmr;

  modport slave (
    input  core_req, core_wr, core_addr, core_wdata, ram_rdata,
    output core_rdata, core_ack, core_err, ram_addr, ram_en, ram_wr,
           ram_wdata, io_addr, io_wr, io_en_gpio, io_en_tmr
  );

  modport master (
    output core_req, core_wr, core_addr, core_wdata, ram_rdata,
    input  core_rdata, core_ack, core_err, ram_addr, ram_en, ram_wr,
           ram_wdata, io_addr, io_wr, io_en_gpio, io_en_tmr
  );
endinterface

// File: rtl/mem_bus_ctrl_addr_decode.sv
// Combinational word-address to region decoder (RAM / GPIO / timer / unmapped).
module mem_addr_decode
  import mem_map_pkg::*;
#(
  parameter logic [11:0] IO_PREFIX = IO_PREFIX_DEF
) (
  input  logic [15:0] addr_i,
  output region_e     region_o
);

  // Region select from the address map
  always_comb begin
    region_o = RGN_NONE;
    if (addr_i < RAM_TOP) begin
      region_o = RGN_RAM;
    end else if (addr_i[15:4] == IO_PREFIX) begin
      case (addr_i[3:2])
        GPIO_BLK: region_o = RGN_GPIO;
        TMR_BLK:  region_o = RGN_TMR;
        default:  region_o = RGN_NONE;
      endcase
    end else begin
      region_o = RGN_NONE;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding load/store sequencer between the core and RAM / I/O page.
// All bus outputs are registered; next-cycle values are derived from state_d.
module mem_bus_ctrl
  import mem_map_pkg::*;
#(
  parameter int          RAM_LAT   = 1,
  parameter logic [11:0] IO_PREFIX = IO_PREFIX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_bus_ctrl_if.slave bus,
  inout  wire  [15:0]   io_data
);

  localparam logic [1:0] LAT_M1 = 2'(RAM_LAT - 1);

  state_e      state_q, state_d;
  region_e     rgn_q, rgn_d, rgn_s;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        ram_en_q, ram_en_d, ram_wr_q, ram_wr_d;
  logic        gpio_q, gpio_d, tmr_q, tmr_d, io_wr_q, io_wr_d;
  logic        ack_q, ack_d, err_q, err_d;
  logic [15:0] rdata_q, rdata_d;
  logic        acc_s;

  mem_addr_decode #(.IO_PREFIX(IO_PREFIX)) u_dec (
    .addr_i   (bus.core_addr),
    .region_o (rgn_s)
  );

  // Next state, request latch and WAIT countdown
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rgn_d   = rgn_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.core_req) begin
          addr_d  = bus.core_addr;
          wdata_d = bus.core_wdata;
          wr_d    = bus.core_wr;
          rgn_d   = rgn_s;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if ((rgn_q == RGN_RAM) && !wr_q) begin
          state_d = ST_WAIT;
          cnt_d   = LAT_M1;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered-output next values; read data is captured on the edge entering RESP
  always_comb begin
    acc_s    = (state_d == ST_ACCESS);
    ram_en_d = acc_s && (rgn_d == RGN_RAM);
    ram_wr_d = ram_en_d && wr_d;
    gpio_d   = acc_s && (rgn_d == RGN_GPIO);
    tmr_d    = acc_s && (rgn_d == RGN_TMR);
    io_wr_d  = acc_s && is_io(rgn_d) && wr_d;
    ack_d    = (state_d == ST_RESP);
    err_d    = ack_d && (rgn_d == RGN_NONE);
    rdata_d  = 16'h0000;
    if (ack_d && (state_q == ST_WAIT)) begin
      rdata_d = bus.ram_rdata;
    end else if (ack_d && (state_q == ST_ACCESS) && is_io(rgn_q) && !wr_q) begin
      rdata_d = io_data;
    end else begin
      rdata_d = 16'h0000;
    end
  end

  // State, latch and output registers; reset aborts any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      wr_q     <= 1'b0;
      rgn_q    <= RGN_NONE;
      cnt_q    <= 2'd0;
      ram_en_q <= 1'b0;
      ram_wr_q <= 1'b0;
      gpio_q   <= 1'b0;
      tmr_q    <= 1'b0;
      io_wr_q  <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      rgn_q    <= rgn_d;
      cnt_q    <= cnt_d;
      ram_en_q <= ram_en_d;
      ram_wr_q <= ram_wr_d;
      gpio_q   <= gpio_d;
      tmr_q    <= tmr_d;
      io_wr_q  <= io_wr_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.core_rdata = rdata_q;
  assign bus.core_ack   = ack_q;
  assign bus.core_err   = err_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_en     = ram_en_q;
  assign bus.ram_wr     = ram_wr_q;
  assign bus.ram_wdata  = wdata_q;
  assign bus.io_addr    = addr_q[1:0];
  assign bus.io_wr      = io_wr_q;
  assign bus.io_en_gpio = gpio_q;
  assign bus.io_en_tmr  = tmr_q;

  // io_wr_q is only ever set in ACCESS for an I/O write, so it doubles as the bus drive enable
  assign io_data = io_wr_q ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: RAM/GPIO/timer models, vector table,
// ack scoreboard and hand-written back-to-back and mid-access reset sequences.
module tb_mem_bus_ctrl;
  import mem_map_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  wire [15:0] io_data;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  mem_bus_ctrl_if bus ();

  mem_bus_ctrl #(.RAM_LAT(LAT), .IO_PREFIX(12'hF00)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .io_data (io_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM, GPIO and timer models
  logic [15:0] mem_r [256];
  logic [15:0] gpio_r [4];
  logic [15:0] tmr_r [4];
  logic [15:0] pipe_r [LAT];
  logic        per_drv;
  logic [15:0] per_val;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_r[i] <= 16'h5000 + 16'(i);
      gpio_r[0] <= 16'h1111; gpio_r[1] <= 16'h2222;
      gpio_r[2] <= 16'hA5A5; gpio_r[3] <= 16'h4444;
      for (int i = 0; i < 4; i++) tmr_r[i] <= 16'h7000 + 16'(i);
      for (int i = 0; i < LAT; i++) pipe_r[i] <= 16'hDEAD;
    end else begin
      if (bus.ram_en && bus.ram_wr) mem_r[bus.ram_addr[7:0]] <= bus.ram_wdata;
      if (bus.io_en_gpio && bus.io_wr) gpio_r[bus.io_addr] <= io_data;
      if (bus.io_en_tmr && bus.io_wr) tmr_r[bus.io_addr] <= io_data;
      pipe_r[0] <= (bus.ram_en && !bus.ram_wr) ? mem_r[bus.ram_addr[7:0]] : 16'hDEAD;
      for (int i = 1; i < LAT; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign bus.ram_rdata = pipe_r[LAT-1];
  assign per_drv = (bus.io_en_gpio || bus.io_en_tmr) && !bus.io_wr;
  assign per_val = bus.io_en_gpio ? gpio_r[bus.io_addr] : tmr_r[bus.io_addr];
  assign io_data = per_drv ? per_val : 16'hzzzz;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          ack_cyc;
    logic [1:0]  kind;   // 0 none, 1 RAM, 2 GPIO, 3 timer
    logic [15:0] wdata;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
    int          lat;
    logic [1:0]  kind;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[15];
  int c_ram, c_gpio, c_tmr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        c_ram = 0; c_gpio = 0; c_tmr = 0;
      end else begin
        if (bus.ram_en) c_ram++;
        if (bus.io_en_gpio) c_gpio++;
        if (bus.io_en_tmr) c_tmr++;
        if (bus.io_wr && sb_q.size() > 0) chk("io_wdata", 32'(io_data), 32'(sb_q[0].wdata));
        if (per_drv) chk("io_rd_bus", 32'(io_data), 32'(per_val));
        if (bus.core_ack) begin
          if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_ack: got ack=1 expected none (cycle %0d)", cyc);
          end else begin
            e = sb_q.pop_front();
            chk("rdata", 32'(bus.core_rdata), 32'(e.rdata));
            chk("err", 32'(bus.core_err), 32'(e.err));
            chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
            chk("ram_en_cnt", 32'(c_ram), 32'(e.kind == 2'd1));
            chk("gpio_en_cnt", 32'(c_gpio), 32'(e.kind == 2'd2));
            chk("tmr_en_cnt", 32'(c_tmr), 32'(e.kind == 2'd3));
          end
          c_ram = 0; c_gpio = 0; c_tmr = 0;
        end
      end
    end
  endtask

  task automatic push(input logic [15:0] rd, input logic err, input int ack_cyc,
                      input logic [1:0] kind, input logic [15:0] wd);
    exp_t e;
    e.rdata = rd; e.err = err; e.ack_cyc = ack_cyc; e.kind = kind; e.wdata = wd;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk); #1;
  endtask

  task automatic issue(input vec_t v);
    push(v.rdata, v.err, cyc + v.lat, v.kind, v.wdata);
    bus.core_req = 1'b1; bus.core_wr = v.wr; bus.core_addr = v.addr; bus.core_wdata = v.wdata;
    @(negedge clk); #1;
    bus.core_req = 1'b0;
    wait_drain(20);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"}, 32'(bus.core_ack), 32'd0);
    chk({tag, "_err"}, 32'(bus.core_err), 32'd0);
    chk({tag, "_rdata"}, 32'(bus.core_rdata), 32'd0);
    chk({tag, "_enables"}, 32'({bus.ram_en, bus.ram_wr, bus.io_en_gpio, bus.io_en_tmr, bus.io_wr}), 32'd0);
    chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
    chk({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 32'd0);
    chk({tag, "_io_addr"}, 32'(bus.io_addr), 32'd0);
  endtask

  initial begin
    vec_t v;
    bus.core_req = 1'b0; bus.core_wr = 1'b0; bus.core_addr = 16'h0000; bus.core_wdata = 16'h0000;
    vecs[0]  = '{1'b1, 16'hF001, 16'h00FF, 16'h0000, 1'b0, 2, 2'd2};
    vecs[1]  = '{1'b0, 16'hF001, 16'h0000, 16'h00FF, 1'b0, 2, 2'd2};
    vecs[2]  = '{1'b0, 16'hF002, 16'h0000, 16'hA5A5, 1'b0, 2, 2'd2};
    vecs[3]  = '{1'b0, 16'hF000, 16'h0000, 16'h1111, 1'b0, 2, 2'd2};
    vecs[4]  = '{1'b1, 16'h0100, 16'h1234, 16'h0000, 1'b0, 2, 2'd1};
    vecs[5]  = '{1'b0, 16'h0100, 16'h0000, 16'h1234, 1'b0, 2 + LAT, 2'd1};
    vecs[6]  = '{1'b0, 16'hEFFF, 16'h0000, 16'h50FF, 1'b0, 2 + LAT, 2'd1};
    vecs[7]  = '{1'b0, 16'hF00C, 16'h0000, 16'h0000, 1'b1, 2, 2'd0};
    vecs[8]  = '{1'b1, 16'hF008, 16'hBEEF, 16'h0000, 1'b1, 2, 2'd0};
    vecs[9]  = '{1'b0, 16'hF010, 16'h0000, 16'h0000, 1'b1, 2, 2'd0};
    vecs[10] = '{1'b1, 16'hF005, 16'hCAFE, 16'h0000, 1'b0, 2, 2'd3};
    vecs[11] = '{1'b0, 16'hF005, 16'h0000, 16'hCAFE, 1'b0, 2, 2'd3};
    vecs[12] = '{1'b0, 16'hF007, 16'h0000, 16'h7003, 1'b0, 2, 2'd3};
    vecs[13] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 2, 2'd0};
    vecs[14] = '{1'b0, 16'h0001, 16'h0000, 16'h5001, 1'b0, 2 + LAT, 2'd1};

    fork monitor(); join_none

    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk); #1;

    for (int i = 0; i < 15; i++) issue(vecs[i]);

    // Back-to-back: GPIO write F000 then timer read F004 with req held high
    push(16'h0000, 1'b0, cyc + 2, 2'd2, 16'h0F0F);
    push(16'h7000, 1'b0, cyc + 5, 2'd3, 16'h0000);
    bus.core_req = 1'b1; bus.core_wr = 1'b1; bus.core_addr = 16'hF000; bus.core_wdata = 16'h0F0F;
    @(negedge clk); #1;
    bus.core_wr = 1'b0; bus.core_addr = 16'hF004; bus.core_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    bus.core_req = 1'b0;
    wait_drain(20);
    v = '{1'b0, 16'hF000, 16'h0000, 16'h0F0F, 1'b0, 2, 2'd2};
    issue(v);

    // Reset during WAIT of a RAM read: no ack, outputs cleared at once
    bus.core_req = 1'b1; bus.core_wr = 1'b0; bus.core_addr = 16'h0002; bus.core_wdata = 16'h0000;
    @(negedge clk); #1;
    bus.core_req = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    v = '{1'b0, 16'h0002, 16'h0000, 16'h5002, 1'b0, 2 + LAT, 2'd1};
    issue(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
